// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-mode PWM engine.
// Imported by the channel and top-level modules.
package pwm_pkg;

   typedef enum logic [1:0] {
      CFG_PERIOD = 2'd0,
      CFG_DUTY   = 2'd1,
      CFG_CTRL   = 2'd2,
      CFG_RSVD   = 2'd3
   } cfg_field_e;

   localparam int CTRL_CENTER_BIT = 0;
   localparam int CTRL_INVERT_BIT = 1;

   typedef struct packed {
      logic center;
      logic invert;
   } pwm_mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } cnt_dir_e;

   function automatic pwm_mode_t ctrl_decode(input logic center_bit, input logic invert_bit);
      pwm_mode_t m;
      m.center = center_bit;
      m.invert = invert_bit;
      return m;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered period/duty/mode, edge or center counter,
// registered compare output and registered period-boundary strobe.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 tick,
   input  logic                 wr_period,
   input  logic                 wr_duty,
   input  logic                 wr_ctrl,
   input  logic [CNT_WIDTH-1:0] wdata,
   output logic                 pwm_out,
   output logic                 period_done
);

   logic [CNT_WIDTH-1:0] period_a, duty_a, period_p, duty_p;
   pwm_mode_t            mode_a, mode_p;
   logic                 pend_q;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   cnt_dir_e             dir_q, dir_d;
   logic                 boundary;
   logic                 wr_any;
   logic                 raw;

   assign wr_any = wr_period | wr_duty | wr_ctrl;
   assign raw    = (cnt_q < duty_a);

   always_comb begin
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      boundary = 1'b0;
      if (tick) begin
         if (!mode_a.center) begin
            if (cnt_q == period_a) begin
               cnt_d    = '0;
               boundary = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (period_a == '0) begin
            cnt_d    = '0;
            boundary = 1'b1;
         end else if ((dir_q == DIR_UP) && (cnt_q != period_a)) begin
            cnt_d = cnt_q + 1'b1;
         end else if (cnt_q <= CNT_WIDTH'(1)) begin
            // Stepping down onto zero closes the center-aligned cycle.
            cnt_d    = '0;
            dir_d    = DIR_UP;
            boundary = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
            dir_d = DIR_DOWN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_a    <= '0;
         duty_a      <= '0;
         mode_a      <= '0;
         period_p    <= '0;
         duty_p      <= '0;
         mode_p      <= '0;
         pend_q      <= 1'b0;
         cnt_q       <= '0;
         dir_q       <= DIR_UP;
         pwm_out     <= 1'b0;
         period_done <= 1'b0;
      end else begin
         if (wr_period) period_p <= wdata;
         if (wr_duty)   duty_p   <= wdata;
         if (wr_ctrl)   mode_p   <= ctrl_decode(wdata[CTRL_CENTER_BIT], wdata[CTRL_INVERT_BIT]);

         if (!run) begin
            // Idle: shadow follows pending continuously, output rests at idle level.
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            period_a    <= period_p;
            duty_a      <= duty_p;
            mode_a      <= mode_p;
            pend_q      <= wr_any;
            pwm_out     <= mode_a.invert;
            period_done <= 1'b0;
         end else begin
            pwm_out     <= raw ^ mode_a.invert;
            period_done <= boundary;
            if (boundary && pend_q) begin
               period_a <= period_p;
               duty_a   <= duty_p;
               mode_a   <= mode_p;
               cnt_q    <= '0;
               dir_q    <= DIR_UP;
            end else begin
               cnt_q <= cnt_d;
               dir_q <= dir_d;
            end
            // A write on a boundary cycle survives the commit and waits for the next one.
            if (wr_any) begin
               pend_q <= 1'b1;
            end else if (boundary) begin
               pend_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/pwm_multimode_core.sv
// Multi-channel PWM engine: shared prescaler, config-write decode and
// NUM_CHANNELS independent pwm_channel instances.
module pwm_multimode_core
   import pwm_pkg::*;
#(
   parameter int NUM_CHANNELS   = 8,
   parameter int CNT_WIDTH      = 16,
   parameter int PRESCALE_WIDTH = 16,
   parameter int CH_IDX_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_we,
   input  logic [CH_IDX_WIDTH-1:0]   cfg_ch,
   input  logic [1:0]                cfg_field,
   input  logic [CNT_WIDTH-1:0]      cfg_wdata,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      global_en,
   input  logic [NUM_CHANNELS-1:0]   ch_en,
   output logic [NUM_CHANNELS-1:0]   pwm_out,
   output logic [NUM_CHANNELS-1:0]   period_done
);

   logic [PRESCALE_WIDTH-1:0] pcnt_q;
   logic                      tick;
   logic                      cfg_valid;
   cfg_field_e                field;

   // >= rather than == so a prescale lowered below pcnt recovers at once.
   assign tick = global_en && (pcnt_q >= prescale);

   always_ff @(posedge clk) begin
      if (rst || !global_en) begin
         pcnt_q <= '0;
      end else if (tick) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_q + 1'b1;
      end
   end

   // Config port: cfg_we is a valid-only strobe with no ready; every asserted
   // cycle is one accepted write, landing in pending state on the next edge.
   assign field     = cfg_field_e'(cfg_field);
   assign cfg_valid = cfg_we && (int'(cfg_ch) < NUM_CHANNELS) && (field != CFG_RSVD);

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      logic sel;
      assign sel = cfg_valid && (cfg_ch == CH_IDX_WIDTH'(i));

      pwm_channel #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .run         (global_en & ch_en[i]),
         .tick        (tick),
         .wr_period   (sel && (field == CFG_PERIOD)),
         .wr_duty     (sel && (field == CFG_DUTY)),
         .wr_ctrl     (sel && (field == CFG_CTRL)),
         .wdata       (cfg_wdata),
         .pwm_out     (pwm_out[i]),
         .period_done (period_done[i])
      );
   end

endmodule

// File: tb/tb_pwm_multimode_core.sv
// Self-checking bench for pwm_multimode_core: table of single-channel waveforms
// plus hand-written sequences for shadow updates, enables, invalid writes and reset.
module tb_pwm_multimode_core;
   import pwm_pkg::*;

   localparam int NC  = 6;
   localparam int CW  = 16;
   localparam int PW  = 16;
   localparam int CIW = 3;

   logic          clk;
   logic          rst;
   logic          cfg_we;
   logic [CIW-1:0] cfg_ch;
   logic [1:0]    cfg_field;
   logic [CW-1:0] cfg_wdata;
   logic [PW-1:0] prescale;
   logic          global_en;
   logic [NC-1:0] ch_en;
   logic [NC-1:0] pwm_out;
   logic [NC-1:0] period_done;

   int n_cmp = 0;
   int n_err = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      string         name;
      logic [CW-1:0] period;
      logic [CW-1:0] duty;
      logic [CW-1:0] ctrl;
      logic [PW-1:0] pre;
      int            n;
      string         pwm_s;
      string         done_s;
   } vec_t;

   vec_t vecs[10];

   pwm_multimode_core #(
      .NUM_CHANNELS   (NC),
      .CNT_WIDTH      (CW),
      .PRESCALE_WIDTH (PW),
      .CH_IDX_WIDTH   (CIW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_field   (cfg_field),
      .cfg_wdata   (cfg_wdata),
      .prescale    (prescale),
      .global_en   (global_en),
      .ch_en       (ch_en),
      .pwm_out     (pwm_out),
      .period_done (period_done)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running required finished");
      $fatal(1);
   end

   task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %b required %b", name, idx, act, exp);
      end
   endtask

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      cfg_we    = 1'b0;
      cfg_ch    = '0;
      cfg_field = '0;
      cfg_wdata = '0;
      prescale  = '0;
      global_en = 1'b0;
      ch_en     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drive_wr(input logic [CIW-1:0] ch, input logic [1:0] fld, input logic [CW-1:0] data);
      cfg_we    = 1'b1;
      cfg_ch    = ch;
      cfg_field = fld;
      cfg_wdata = data;
   endtask

   task automatic cfg_write(input logic [CIW-1:0] ch, input logic [1:0] fld, input logic [CW-1:0] data);
      @(negedge clk);
      drive_wr(ch, fld, data);
   endtask

   task automatic setup_ch(input logic [CIW-1:0] ch, input logic [CW-1:0] per,
                           input logic [CW-1:0] dty, input logic [CW-1:0] ctl);
      cfg_write(ch, CFG_PERIOD, per);
      cfg_write(ch, CFG_DUTY, dty);
      cfg_write(ch, CFG_CTRL, ctl);
   endtask

   task automatic settle();
      @(negedge clk);
      cfg_we = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Enables the masked channels and checks n cycles of pwm/done against the
   // pattern strings (char i = sample after the i+1-th edge). Up to two duty
   // writes to ch0 are driven so they land on edge wrX_cyc+1.
   task automatic run_check(input string name, input logic [NC-1:0] mask, input int n,
                            input string pwm_s, input string done_s,
                            input int wr0_cyc, input logic [CW-1:0] wr0_data,
                            input int wr1_cyc, input logic [CW-1:0] wr1_data);
      logic [3:0] exp;
      logic       ep, ed;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            exp = exp_q.pop_front();
            for (int c = 0; c < NC; c++) begin
               if (mask[c]) check(name, i, 16'({pwm_out[c], period_done[c]}), 16'(exp[1:0]));
            end
         end
         cfg_we = 1'b0;
         if (i < n) begin
            global_en = 1'b1;
            ch_en     = mask;
            if (i == wr0_cyc) drive_wr('0, CFG_DUTY, wr0_data);
            if (i == wr1_cyc) drive_wr('0, CFG_DUTY, wr1_data);
            ep = (pwm_s[i] == "1");
            ed = (done_s[i] == "1");
            exp_q.push_back({2'b00, ep, ed});
         end
      end
   endtask

   initial begin
      vecs[0] = '{"edge_p4_d2",     16'd4, 16'd2, 16'd0, 16'd0, 10, "1100011000", "0000100001"};
      vecs[1] = '{"center_inv",     16'd4, 16'd2, 16'd3, 16'd0, 16, "0011111000111110", "0000000100000001"};
      vecs[2] = '{"duty0",          16'd4, 16'd0, 16'd0, 16'd0, 10, "0000000000", "0000100001"};
      vecs[3] = '{"duty_gt_period", 16'd4, 16'd5, 16'd0, 16'd0, 10, "1111111111", "0000100001"};
      vecs[4] = '{"prescale2",      16'd4, 16'd2, 16'd0, 16'd2, 30,
                  "111111000000000111111000000000", "000000000000001000000000000001"};
      vecs[5] = '{"edge_p0",        16'd0, 16'd1, 16'd0, 16'd0, 5, "11111", "11111"};
      vecs[6] = '{"center_p0",      16'd0, 16'd0, 16'd1, 16'd0, 5, "00000", "11111"};
      vecs[7] = '{"center_p0_inv",  16'd0, 16'd0, 16'd3, 16'd0, 5, "11111", "11111"};
      vecs[8] = '{"edge_inv_p2",    16'd2, 16'd1, 16'd2, 16'd0, 6, "011011", "001001"};
      vecs[9] = '{"center_p1",      16'd1, 16'd1, 16'd1, 16'd0, 8, "10101010", "01010101"};

      rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_field = '0; cfg_wdata = '0;
      prescale = '0; global_en = 1'b0; ch_en = '0;

      do_reset();
      check("reset_pwm", 0, 16'(pwm_out), 16'(0));
      check("reset_done", 0, 16'(period_done), 16'(0));

      // waveform table
      for (int v = 0; v < 10; v++) begin
         do_reset();
         prescale = vecs[v].pre;
         setup_ch('0, vecs[v].period, vecs[v].duty, vecs[v].ctrl);
         settle();
         check({vecs[v].name, "_idle"}, 0, 16'({period_done[0], pwm_out[0]}), 16'({1'b0, vecs[v].ctrl[1]}));
         run_check(vecs[v].name, 6'b000001, vecs[v].n, vecs[v].pwm_s, vecs[v].done_s, -1, '0, -1, '0);
      end

      // duty change mid-cycle applies at the next boundary
      do_reset();
      setup_ch('0, 16'd4, 16'd2, 16'd0);
      settle();
      run_check("shadow_mid", 6'b000001, 15, "110001110011100", "000010000100001", 2, 16'd3, -1, '0);

      // write on a boundary cycle: old pending commits, new one waits a period
      do_reset();
      setup_ch('0, 16'd4, 16'd2, 16'd0);
      settle();
      run_check("shadow_boundary", 6'b000001, 15, "110001000011100", "000010000100001", 2, 16'd1, 4, 16'd3);

      // invalid channel / reserved field writes leave state untouched
      do_reset();
      setup_ch('0, 16'd4, 16'd2, 16'd0);
      setup_ch(3'd2, 16'd4, 16'd2, 16'd0);
      cfg_write(3'd6, CFG_DUTY, 16'd0);
      cfg_write(3'd7, CFG_PERIOD, 16'd1);
      cfg_write(3'd0, CFG_RSVD, 16'hFFFF);
      cfg_write(3'd2, CFG_RSVD, 16'hFFFF);
      settle();
      check("invalid_idle", 0, 16'(pwm_out), 16'(0));
      run_check("invalid_wr", 6'b000101, 10, "1100011000", "0000100001", -1, '0, -1, '0);

      // ch1 enable toggled mid-cycle; ch0 must not notice
      do_reset();
      setup_ch('0, 16'd4, 16'd2, 16'd0);
      setup_ch(3'd1, 16'd4, 16'd2, 16'd2);
      settle();
      begin
         string en1_s, p0_s, d0_s, p1_s, d1_s;
         logic [3:0] exp;
         en1_s = "110000111111";
         p0_s  = "110001100011";
         d0_s  = "000010000100";
         p1_s  = "001111001110";
         d1_s  = "000000000010";
         for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
               exp = exp_q.pop_front();
               check("en_toggle", i, 16'({pwm_out[0], period_done[0], pwm_out[1], period_done[1]}), 16'(exp));
            end
            if (i < 12) begin
               global_en = 1'b1;
               ch_en     = {4'b0000, en1_s[i] == "1", 1'b1};
               exp_q.push_back({p0_s[i] == "1", d0_s[i] == "1", p1_s[i] == "1", d1_s[i] == "1"});
            end
         end
      end

      // reset mid-operation with a pending write outstanding
      do_reset();
      setup_ch('0, 16'd4, 16'd2, 16'd0);
      settle();
      run_check("pre_reset", 6'b000001, 7, "1100011", "0000100", -1, '0, -1, '0);
      drive_wr('0, CFG_DUTY, 16'd3);
      @(negedge clk);
      cfg_we = 1'b0;
      rst    = 1'b1;
      @(negedge clk);
      check("midrst_pwm", 0, 16'(pwm_out), 16'(0));
      check("midrst_done", 0, 16'(period_done), 16'(0));
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("cold_pwm", i, 16'(pwm_out), 16'(0));
         check("cold_done", i, 16'(period_done), 16'(6'b000001));
      end

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
